muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit for MULT/MULTU/DIV/DIVU and MTHI/MTLO in the EX stage, beside the ALU.
//  Takes the same A/B operands the ALU does and owns the HI/LO architectural registers.
//  Exposes HI/LO for MFHI/MFLO. Asserts busy so the hazard unit stalls any MF*/MT*/mul/div issued while it runs.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are WIDTH bits each; iteration count = WIDTH
// PORTS
//  clk    in   1      rising-edge clock (one clock domain)
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      launch op; sampled only when busy=0
//  op     in   2      MD_MULT=00, MD_MULTU=01, MD_DIV=10, MD_DIVU=11
//  A      in   WIDTH  rs operand (multiplicand/dividend)
//  B      in   WIDTH  rt operand (multiplier/divisor)
//  mthi   in   1      write wdata into HI
//  mtlo   in   1      write wdata into LO
//  wdata  in   WIDTH  MTHI/MTLO data
//  busy   out  1      op in flight; pipeline must stall MF*/MT*/mul/div
//  done   out  1      one-cycle pulse: HI/LO just updated by an op
//  hi     out  WIDTH  HI register
//  lo     out  WIDTH  LO register
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, cnt=0, busy=0, done=0, hi=0, lo=0.
//  FSM states are IDLE, RUN and FIX. busy=1 in RUN and FIX. busy is a registered output.
//  IDLE with start=1 at edge E0:
//   - Latch op, operand signs, |A| and |B|. Use the absolute values only for signed ops.
//   - Clear the accumulator and set cnt=0. Go to RUN.
//  RUN: one radix-2 step per edge, then cnt++. At the edge where cnt==WIDTH-1, go to FIX.
//   - Multiply: shift-add into a 2*WIDTH-bit product.
//   - Divide: restoring shift-subtract into a quotient and a remainder.
//  FIX, one edge at E0+WIDTH+1 (E33 for WIDTH=32):
//   - Apply sign correction and write HI/LO. Then go to IDLE and set done=1 for exactly one cycle.
//   - Total latency is 34 edges from start; busy is high for 33 cycles.
//  Multiply result: {hi,lo} = full 64-bit product. For MULT the product is negated if the operand signs differ.
//  Divide result: lo = quotient, hi = remainder.
//   - DIV: the quotient is negated if the signs differ; the remainder takes the sign of the dividend.
//   - The division is truncating, toward zero.
//  Divide by zero, DIV or DIVU: lo=all ones and hi=A. Skip sign correction in this case.
//  DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is not an error; there is no exception output.
//  Operands are sampled only at start. A/B/op changes during RUN have no effect.
//  start while busy=1: ignored. The hazard unit is responsible for not issuing it.
//  mthi/mtlo while busy=0: hi/lo=wdata at the next edge. Both may be set in the same cycle.
//  mthi/mtlo while busy=1: ignored.
//  start and mthi/mtlo in the same IDLE cycle: start wins and the MT* write is dropped.
//  hi/lo hold their old values throughout RUN. They change only at FIX or on an MT* write.
// STRUCTURE
//  Shared include MulDivop.vh, alongside ALUop.vh, holds:
//   - MD_MULT, MD_MULTU, MD_DIV, MD_DIVU op codes
//   - the decode of funct -> op/mthi/mtlo, used by the controller
//  FSM state encodings are localparams local to this module.
//  One sub-module: muldiv_step, a combinational single iteration.
//   - Inputs: mode, accumulator, operand. Outputs: next accumulator, next quotient bit.
//  This module holds the FSM, the counter, sign fixup and the HI/LO registers.
// TESTING
//  1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done pulses once, 34 edges after start; busy high 33 cycles.
//  2. MULT 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Change A/B mid-RUN: result unchanged.
//  3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  4. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  5. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
//  6. MTHI 0x1234 while idle -> hi=0x1234 next edge.
//  7. MTLO during RUN -> lo unchanged.
//  8. start+mthi in the same cycle -> hi untouched until FIX.
//  9. start during RUN -> ignored, and the in-flight result is correct.
//  10. Assert rst asynchronously at cnt=10 -> busy=0, hi=lo=0 immediately with no clock edge.
//  11. A start after that reset completes normally with correct results.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - op codes and funct decode shared by the mul/div unit and its controller
package muldiv_unit_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef struct packed {
    logic       start;
    logic [1:0] op;
    logic       mthi;
    logic       mtlo;
  } md_ctrl_t;

  // The low two funct bits of MULT..DIVU line up with the MD_* codes.
  function automatic md_ctrl_t decode_funct(input logic [5:0] funct);
    md_ctrl_t c;
    c = '0;
    case (funct)
      6'h11: c.mthi = 1'b1;
      6'h13: c.mtlo = 1'b1;
      6'h18, 6'h19, 6'h1A, 6'h1B: begin
        c.start = 1'b1;
        c.op    = funct[1:0];
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational radix-2 iteration (shift-add multiply or restoring divide)
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 divide,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next,
  output logic                 q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  // Multiply: upper half accumulates, low half holds the unconsumed multiplier bits.
  // Divide: upper half is the remainder, low half shifts dividend out and quotient in.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    partial  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = partial - {1'b0, operand};
    q_bit    = 1'b0;
    acc_next = {sum, acc[WIDTH-1:1]};
    if (divide) begin
      q_bit    = ~diff[WIDTH];
      acc_next = {(q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t             state, next_state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   operand, a_q;
  logic [2*WIDTH-1:0] acc, step_acc;
  logic               step_q;
  logic               op_div, op_signed, start_signed;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign op_div       = op_q[1];
  assign op_signed    = (op_q == MD_MULT) || (op_q == MD_DIV);
  assign start_signed = (op == MD_MULT) || (op == MD_DIV);
  assign abs_a        = (start_signed && A[WIDTH-1]) ? -A : A;
  assign abs_b        = (start_signed && B[WIDTH-1]) ? -B : B;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .divide   (op_div),
    .acc      (acc),
    .operand  (operand),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (state == FIX);
    end
  end

  // Divide by zero leaves the raw dividend in HI and bypasses sign correction.
  always_comb begin
    fix_hi = acc[2*WIDTH-1:WIDTH];
    fix_lo = acc[WIDTH-1:0];
    if (!op_div) begin
      if (op_signed && (sign_a ^ sign_b)) {fix_hi, fix_lo} = -acc;
    end else if (operand == '0) begin
      fix_hi = a_q;
      fix_lo = '1;
    end else if (op_signed) begin
      if (sign_a ^ sign_b) fix_lo = -acc[WIDTH-1:0];
      if (sign_a)          fix_hi = -acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      op_q    <= MD_MULT;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      operand <= '0;
      a_q     <= '0;
      acc     <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            sign_a <= A[WIDTH-1];
            sign_b <= B[WIDTH-1];
            a_q    <= A;
            cnt    <= '0;
            if (op[1]) begin
              acc     <= {{WIDTH{1'b0}}, abs_a};
              operand <= abs_b;
            end else begin
              acc     <= {{WIDTH{1'b0}}, abs_b};
              operand <= abs_a;
            end
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          acc <= op_div ? {step_acc[2*WIDTH-1:1], step_q} : step_acc;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] a_in, b_in, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [W-1:0] cur_hi = '0, cur_lo = '0;
  int edges, busy_cycles;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(a_in), .B(b_in),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] q, r;
    case (o)
      MD_MULT:  p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      MD_MULTU: p = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else if (o == MD_DIVU) p = {a % b, a / b};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
        else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          p = {r, q};
        end
      end
    endcase
    return p;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    exp_q.push_back(model(o, a, b));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int n_edges, output int n_busy);
    logic [63:0] e;
    bit seen;
    seen = 0; n_edges = 0; n_busy = busy ? 1 : 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      n_edges++;
      if (done) seen = 1;
      else if (busy) n_busy++;
    end
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: done never rose within 40 cycles", name);
    end else begin
      checks++;
      if (hi !== e[63:32]) begin
        errors++;
        $display("FAIL %s hi: got %h expected %h", name, hi, e[63:32]);
      end
      checks++;
      if (lo !== e[31:0]) begin
        errors++;
        $display("FAIL %s lo: got %h expected %h", name, lo, e[31:0]);
      end
    end
    cur_hi = e[63:32];
    cur_lo = e[31:0];
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, hi, lo} !== {1'b0, 1'b0, 64'h0}) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo);
    end
  endtask

  task automatic test_multu_timing();
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_max", edges, busy_cycles);
    checks++;
    if (edges !== 33) begin
      errors++;
      $display("FAIL multu_latency: done after %0d edges past start edge, expected 33", edges);
    end
    checks++;
    if (busy_cycles !== 33) begin
      errors++;
      $display("FAIL multu_busy_cycles: got %0d expected 33", busy_cycles);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_at_done: got %b expected 0", busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_single_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_mult_operand_change();
    issue(MD_MULT, 32'hFFFFFFFD, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    a_in = 32'h12345678; b_in = 32'h9ABCDEF0; op = MD_DIVU;
    wait_done("mult_neg_change", edges, busy_cycles);
  endtask

  task automatic test_divides();
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("div_neg7_2", edges, busy_cycles);
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_overflow", edges, busy_cycles);
    issue(MD_DIVU, 32'd7, 32'd0);
    wait_done("divu_by_zero", edges, busy_cycles);
    issue(MD_DIV, 32'hFFFFFFF0, 32'd0);
    wait_done("div_by_zero_neg", edges, busy_cycles);
  endtask

  task automatic test_mt_idle();
    @(negedge clk);
    mthi = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    mthi = 1'b0;
    checks++;
    if (hi !== 32'h1234) begin
      errors++;
      $display("FAIL mthi_idle: got %h expected 00001234", hi);
    end
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if ({hi, lo} !== {32'hCAFEF00D, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL mthi_mtlo_both: got hi=%h lo=%h expected cafef00d", hi, lo);
    end
    cur_hi = 32'hCAFEF00D;
    cur_lo = 32'hCAFEF00D;
  endtask

  task automatic test_mt_during_run();
    issue(MD_MULTU, 32'd1000, 32'd3000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    mtlo = 1'b1; mthi = 1'b1; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    mtlo = 1'b0; mthi = 1'b0;
    checks++;
    if ({hi, lo} !== {cur_hi, cur_lo}) begin
      errors++;
      $display("FAIL mt_during_run: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, cur_hi, cur_lo);
    end
    wait_done("mt_during_run_result", edges, busy_cycles);
  endtask

  task automatic test_start_with_mthi();
    @(negedge clk);
    start = 1'b1; op = MD_DIVU; a_in = 32'd100; b_in = 32'd7; mthi = 1'b1; wdata = 32'h5555;
    exp_q.push_back(model(MD_DIVU, 32'd100, 32'd7));
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    checks++;
    if (hi !== cur_hi) begin
      errors++;
      $display("FAIL start_mthi_dropped: got %h expected %h", hi, cur_hi);
    end
    repeat (20) @(posedge clk); #1;
    checks++;
    if (hi !== cur_hi) begin
      errors++;
      $display("FAIL hi_held_in_run: got %h expected %h", hi, cur_hi);
    end
    wait_done("start_mthi_result", edges, busy_cycles);
  endtask

  task automatic test_start_during_run();
    issue(MD_MULT, 32'h7FFFFFFF, 32'h80000000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = MD_DIV; a_in = 32'd9; b_in = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("start_during_run", edges, busy_cycles);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_launched: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] dropped;
    issue(MD_DIV, 32'd12345, 32'd17);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, hi, lo} !== {1'b0, 64'h0}) begin
      errors++;
      $display("FAIL async_reset: got busy=%b hi=%h lo=%h expected 0", busy, hi, lo);
    end
    dropped = exp_q.pop_back();
    @(negedge clk);
    rst = 1'b0;
    cur_hi = '0;
    cur_lo = '0;
    issue(MD_DIV, 32'hFFFFFF9C, 32'd7);
    wait_done("after_reset_div", edges, busy_cycles);
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(3));
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : 32'($urandom_range(15)) - 32'd5;
      issue(o, a, b);
      wait_done("random", edges, busy_cycles);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = MD_MULT; a_in = '0; b_in = '0; wdata = '0;
    repeat (2) @(posedge clk); #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_multu_timing();
    test_mult_operand_change();
    test_divides();
    test_mt_idle();
    test_mt_during_run();
    test_start_with_mthi();
    test_start_during_run();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
